// File: rtl/bus_reduce_fifo.sv
// Purpose: reduces NUM_OPS operands with AND/OR/XOR/ADD and queues the results for a stalling consumer.
// Latency: 1 cycle from input accept to out_valid when the queue is empty. No combinational in->out path.
// Backpressure: in_ready = (count < DEPTH) and is not relieved by a same-cycle pop; the head holds while out_ready=0.

// Purpose: generic DEPTH-entry FIFO with a registered head-of-queue output.
// Latency: a push into an empty FIFO is visible at pop_dat/pop_vld on the next cycle.
// Backpressure: push_rdy is low while full, even if a pop happens in the same cycle.
module fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_vld,
    output logic          push_rdy,
    input  logic [DW-1:0] push_dat,
    output logic          pop_vld,
    input  logic          pop_rdy,
    output logic [DW-1:0] pop_dat,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_nxt;
    logic [CW-1:0] count_nxt;
    logic          do_push;
    logic          do_pop;

    assign push_rdy = (count != FULL_CNT);
    assign pop_vld  = (count != '0);
    assign do_push  = push_vld & push_rdy;
    assign do_pop   = pop_vld & pop_rdy;

    // Next read pointer and occupancy; a push and a pop together leave the occupancy unchanged
    always_comb begin
        rd_ptr_nxt = do_pop ? rd_ptr + PW'(1) : rd_ptr;
        count_nxt  = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage array; stale entries are never visible because the head is held in its own register
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers, occupancy and registered head. The head bypasses the array when the new write becomes the head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pop_dat <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            if (do_push && (wr_ptr == rd_ptr_nxt)) begin
                pop_dat <= push_dat;
            end else if (count_nxt != '0) begin
                pop_dat <= mem[rd_ptr_nxt];
            end
        end
    end
endmodule

// Purpose: reduces an operand group with a selectable operator and buffers the {carry,result} pairs.
// Latency: 1 cycle from accept to out_valid on an empty FIFO.
// Backpressure: in_ready low when DEPTH results are queued; out_* hold while out_ready=0.
module bus_reduce_fifo #(
    parameter int WIDTH   = 8,
    parameter int NUM_OPS = 3,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_OPS*WIDTH-1:0]   in_ops,
    input  logic [1:0]                 in_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_carry,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                txn_count
);
    localparam int SW = WIDTH + $clog2(NUM_OPS);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [1:0] MODE_AND = 2'd0;
    localparam logic [1:0] MODE_OR  = 2'd1;
    localparam logic [1:0] MODE_XOR = 2'd2;

    logic [WIDTH-1:0] op;
    logic [WIDTH-1:0] red_and;
    logic [WIDTH-1:0] red_or;
    logic [WIDTH-1:0] red_xor;
    logic [SW-1:0]    red_sum;
    logic [WIDTH-1:0] red_res;
    logic             red_carry;
    logic [WIDTH:0]   head_dat;
    logic             accept;

    // Reduce all operands under every operator, then pick by mode; the sum is wide enough never to wrap
    always_comb begin
        op      = '0;
        red_and = '1;
        red_or  = '0;
        red_xor = '0;
        red_sum = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            op      = in_ops[k*WIDTH +: WIDTH];
            red_and = red_and & op;
            red_or  = red_or | op;
            red_xor = red_xor ^ op;
            red_sum = red_sum + {{(SW-WIDTH){1'b0}}, op};
        end
        red_carry = 1'b0;
        case (in_mode)
            MODE_AND: red_res = red_and;
            MODE_OR:  red_res = red_or;
            MODE_XOR: red_res = red_xor;
            default: begin
                red_res   = red_sum[WIDTH-1:0];
                red_carry = |red_sum[SW-1:WIDTH];
            end
        endcase
    end

    fifo #(
        .DW    (WIDTH + 1),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat ({red_carry, red_res}),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (head_dat),
        .count    (count)
    );

    assign out_data  = head_dat[WIDTH-1:0];
    assign out_carry = head_dat[WIDTH];
    assign accept    = in_valid & in_ready;

    // Count accepted operand sets; wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
        end else if (accept) begin
            txn_count <= txn_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_bus_reduce_fifo.sv
// Bench for bus_reduce_fifo: directed steps plus random traffic against a queue-based reference.
// Instance u0 is 8-bit/3-operand/4-deep; instance u1 is 16-bit/4-operand for wide ADD and counter wrap.
// Outputs are sampled 1 time unit after the rising edge; inputs are driven at the same point.
module tb_bus_reduce_fifo;
    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, out_carry;
    logic [23:0] in_ops;
    logic [1:0]  in_mode;
    logic [7:0]  out_data;
    logic [2:0]  count;
    logic [15:0] txn_count;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_carry;
    logic [63:0] b_in_ops;
    logic [1:0]  b_in_mode;
    logic [15:0] b_out_data;
    logic [2:0]  b_count;
    logic [15:0] b_txn_count;

    int tot = 0;
    int bad = 0;
    int mtxn = 0;
    logic [8:0] q[$];

    localparam logic [1:0] MAND = 2'd0, MOR = 2'd1, MXOR = 2'd2, MADD = 2'd3;

    bus_reduce_fifo #(.WIDTH(8), .NUM_OPS(3), .DEPTH(4)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ops(in_ops), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_carry(out_carry), .count(count), .txn_count(txn_count)
    );

    bus_reduce_fifo #(.WIDTH(16), .NUM_OPS(4), .DEPTH(4)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_ops(b_in_ops), .in_mode(b_in_mode), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_carry(b_out_carry), .count(b_count), .txn_count(b_txn_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference reduction from the operator definitions using plain integer arithmetic
    function automatic logic [8:0] ref_red(input logic [1:0] m, input logic [7:0] a, b, c);
        int s;
        case (m)
            MAND:    return {1'b0, a & b & c};
            MOR:     return {1'b0, a | b | c};
            MXOR:    return {1'b0, a ^ b ^ c};
            default: begin
                s = int'(a) + int'(b) + int'(c);
                return {s > 255, s[7:0]};
            end
        endcase
    endfunction

    task automatic drv(input bit v, input logic [1:0] m, input logic [7:0] a, b, c, input bit ordy);
        in_valid  = v;
        in_mode   = m;
        in_ops    = {c, b, a};
        out_ready = ordy;
    endtask

    // Compare u0 against the queue model, then advance one clock and update the model
    task automatic cycle();
        bit         acc, pp;
        logic [8:0] r, h;
        chk("in_ready", in_ready, q.size() < 4);
        chk("count", count, q.size());
        chk("out_valid", out_valid, q.size() != 0);
        chk("txn_count", txn_count, mtxn);
        if (q.size() != 0) begin
            h = q[0];
            chk("out_data", out_data, h[7:0]);
            chk("out_carry", out_carry, h[8]);
        end
        acc = in_valid && (q.size() < 4);
        pp  = out_ready && (q.size() != 0);
        r   = ref_red(in_mode, in_ops[7:0], in_ops[15:8], in_ops[23:16]);
        @(posedge clk);
        if (pp) void'(q.pop_front());
        if (acc) begin
            q.push_back(r);
            mtxn = (mtxn + 1) % 65536;
        end
        #1;
    endtask

    initial begin
        logic [7:0] fa[5], fb[5], fc[5];
        logic [1:0] fm[5];
        int t0;

        rst_n = 1'b1;
        drv(0, MAND, 8'h0, 8'h0, 8'h0, 0);
        b_in_valid = 1'b0; b_in_ops = '0; b_in_mode = MAND; b_out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_txn", txn_count, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_carry", out_carry, 0);
        chk("rst_in_ready", in_ready, 1);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back logic modes and ADD with consumer always ready
        drv(1, MAND, 8'hF0, 8'h3C, 8'hFF, 1); cycle();
        chk("and_vld", out_valid, 1); chk("and_data", out_data, 8'h30); chk("and_carry", out_carry, 0);
        drv(1, MXOR, 8'h0F, 8'hF0, 8'hAA, 1); cycle();
        chk("xor_data", out_data, 8'h55);
        drv(1, MOR, 8'h01, 8'h02, 8'h04, 1); cycle();
        chk("or_data", out_data, 8'h07);
        drv(1, MADD, 8'h80, 8'h80, 8'h01, 1); cycle();
        chk("add_data", out_data, 8'h01); chk("add_carry", out_carry, 1);
        drv(1, MADD, 8'h10, 8'h20, 8'h30, 1); cycle();
        chk("add2_data", out_data, 8'h60); chk("add2_carry", out_carry, 0);
        drv(0, MAND, 8'h0, 8'h0, 8'h0, 1); cycle();
        chk("drained", count, 0);

        // Fill to DEPTH with a stalled consumer; the fifth set must wait
        for (int i = 0; i < 5; i++) begin
            fa[i] = 8'($urandom); fb[i] = 8'($urandom); fc[i] = 8'($urandom);
            fm[i] = 2'($urandom_range(0, 3));
        end
        for (int i = 0; i < 5; i++) begin
            drv(1, fm[i], fa[i], fb[i], fc[i], 0); cycle();
        end
        chk("full_in_ready", in_ready, 0);
        chk("full_count", count, 4);
        chk("full_txn", txn_count, 9);
        drv(1, fm[4], fa[4], fb[4], fc[4], 1); cycle();
        chk("pulse_count", count, 3);
        chk("pulse_in_ready", in_ready, 1);
        drv(1, fm[4], fa[4], fb[4], fc[4], 0); cycle();
        chk("refill_count", count, 4);
        chk("refill_txn", txn_count, 10);
        for (int i = 0; i < 5; i++) begin
            drv(0, MAND, 8'h0, 8'h0, 8'h0, 1); cycle();
        end

        // Push and pop together at count=2
        drv(1, MXOR, 8'h12, 8'h34, 8'h56, 0); cycle();
        drv(1, MAND, 8'hFF, 8'h0F, 8'h3C, 0); cycle();
        chk("pp_pre_count", count, 2);
        chk("pp_oldest", out_data, 8'h70);
        t0 = mtxn;
        drv(1, MOR, 8'h01, 8'h10, 8'h80, 1); cycle();
        chk("pp_count", count, 2);
        chk("pp_next_head", out_data, 8'h0C);
        chk("pp_txn", txn_count, (t0 + 1) % 65536);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            drv(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                8'($urandom), 1'($urandom_range(0, 1)));
            cycle();
        end

        // Asynchronous reset with three entries buffered
        for (int i = 0; i < 5; i++) begin
            drv(0, MAND, 8'h0, 8'h0, 8'h0, 1); cycle();
        end
        for (int i = 0; i < 3; i++) begin
            drv(1, MADD, 8'($urandom), 8'($urandom), 8'($urandom), 0); cycle();
        end
        chk("prerst_count", count, 3);
        drv(0, MAND, 8'h0, 8'h0, 8'h0, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_txn", txn_count, 0);
        chk("arst_in_ready", in_ready, 1);
        q.delete();
        mtxn = 0;
        #2 rst_n = 1'b1;
        drv(1, MAND, 8'hF0, 8'h3C, 8'hFF, 1); cycle();
        chk("postrst_vld", out_valid, 1);
        chk("postrst_data", out_data, 8'h30);
        chk("postrst_txn", txn_count, 1);
        drv(0, MAND, 8'h0, 8'h0, 8'h0, 1); cycle();

        // Wide ADD and 16-bit counter wrap on the second instance
        b_in_ops = {4{16'hFFFF}}; b_in_mode = MADD; b_out_ready = 1'b1; b_in_valid = 1'b1;
        @(posedge clk); #1;
        chk("wide_vld", b_out_valid, 1);
        chk("wide_data", b_out_data, 16'hFFFC);
        chk("wide_carry", b_out_carry, 1);
        chk("wide_txn1", b_txn_count, 1);
        repeat (65534) @(posedge clk);
        #1;
        chk("wide_txn_ffff", b_txn_count, 16'hFFFF);
        chk("wide_count", b_count, 1);
        @(posedge clk); #1;
        chk("wide_txn_wrap", b_txn_count, 0);
        @(posedge clk); #1;
        chk("wide_txn_65537", b_txn_count, 1);
        b_in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule

// File: doc/bus_reduce_fifo.md
Name: bus_reduce_fifo

Overview:
Parametrised successor to the fixed three-operand AND bus consumer. It accepts NUM_OPS operands of WIDTH bits per transaction over a valid/ready handshake. It reduces them with a run-time selectable operator (AND/OR/XOR/ADD) and buffers the results in a DEPTH-entry output FIFO. It sits between a grouped operand bus producer and a downstream consumer that may stall.

Parameters:
WIDTH, 8, operand and result width in bits (1..64)
NUM_OPS, 3, operands per transaction (2..8)
DEPTH, 4, output FIFO entries (power of 2, 2..16)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set valid
in_ready  output  1  block can accept operand set
in_ops  input  NUM_OPS*WIDTH  operands; operand k at bits [k*WIDTH +: WIDTH]
in_mode  input  2  0=AND, 1=OR, 2=XOR, 3=ADD; sampled with in_ops
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_data  output  WIDTH  reduced result at FIFO head
out_carry  output  1  ADD overflow flag of head entry; 0 for logic modes
count  output  $clog2(DEPTH)+1  current FIFO occupancy
txn_count  output  16  accepted-transaction counter, wraps

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- On reset assertion, immediately and regardless of clk:
  - count=0, out_valid=0, txn_count=0, read/write pointers=0.
  - out_data=0, out_carry=0.
  - in_ready=1 once rst_n is high.
- Handshakes:
  - Input transfer occurs on a rising edge with in_valid&&in_ready.
  - Output transfer occurs on a rising edge with out_valid&&out_ready.
- Reduction (combinational from in_ops/in_mode):
  - AND/OR/XOR: bitwise over all NUM_OPS operands; carry=0.
  - ADD: unsigned sum at width WIDTH+$clog2(NUM_OPS). out_data gets the low WIDTH bits. carry=1 iff any higher bit is set.
- Push: the {carry,result} of an accepted set is written at the write pointer. It is visible at out_data/out_valid the cycle after acceptance if the FIFO was empty. Latency is 1 cycle; there is no combinational in->out path.
- in_ready = (count < DEPTH). No pass-through when full, even if a pop occurs in the same cycle.
- out_valid = (count != 0). out_data/out_carry always reflect the head entry. When empty they hold the last popped value (don't-care to consumers).
- Count and ordering:
  - Simultaneous push and pop: count unchanged, pointers both advance, order preserved.
  - Push only: count+1. Pop only: count-1.
  - Pointers wrap modulo DEPTH.
- Stability: while out_valid=1 and out_ready=0, out_data/out_carry/out_valid must remain stable.
- in_valid while in_ready=0 is ignored; no state changes.
- txn_count increments on each input transfer and wraps 0xFFFF->0x0000.
- Reset asserted mid-operation discards all buffered entries. The first post-reset accept lands in entry 0.
- FIFO state machine is implicit in count:
  - EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH).
  - Transitions by push/pop only; never skips more than one level per cycle.

Test Plan:
- WIDTH=8, NUM_OPS=3: modes AND/XOR/OR, one transfer per cycle, out_ready=1.
  - AND, ops {0xF0,0x3C,0xFF} -> next cycle out_valid=1, out_data=0x30, out_carry=0.
  - XOR, ops {0x0F,0xF0,0xAA} -> 0x55.
  - OR, ops {0x01,0x02,0x04} -> 0x07; results in order.
- ADD, ops {0x80,0x80,0x01}: sum 0x101 -> out_data=0x01, out_carry=1. Ops {0x10,0x20,0x30} -> 0x60, carry=0.
- DEPTH=4, out_ready=0, push 5 sets with in_valid held:
  - in_ready drops after the 4th; count=4; 5th not accepted; txn_count=4.
  - Pulse out_ready 1 cycle -> count=3, in_ready=1; 5th accepted next edge; FIFO order intact.
- count=2, push and pop in the same cycle -> count stays 2; popped value is the oldest; txn_count+1.
- 3 entries buffered, assert rst_n=0 asynchronously mid-cycle -> out_valid=0, count=0, txn_count=0 before the next edge. After release, first result appears 1 cycle after accept.
- WIDTH=16, NUM_OPS=4: ADD of 4x0xFFFF (sum 0x3FFFC) -> out_data=0xFFFC, out_carry=1.
  - Separately, drive 65537 transfers -> txn_count=0x0001.
